network_controller: RTL and testbench
=====================================

Name: network_controller

Overview:
Neuron-layer compute stage directly downstream of the ROM weight loader. It captures the four 32-bit weight words written by the loader into a local weight bank. On the loader's start pulse it evaluates a 4-input, 4-unit perceptron layer against a 32-bit sample, one signed MAC per cycle. It presents a 4-bit step-activated result with a one-cycle done pulse.

Parameters:
THRESHOLD, 0, signed 18-bit activation threshold; unit fires when its sum > THRESHOLD (strict)
NUM_UNITS, 4, number of units and bank words; fixed at 4 (2-bit address)

Ports:
clk  in  1  single system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
weight_data  in  32  weight word from ROM; bit 31 = MSB; byte k = [8k+7:8k] = signed 8-bit weight for input k
address  in  2  bank index (unit number) for weight_data
writeData  in  1  write strobe; bank[address] <= weight_data on rising edge when accepted
start_network_controller  in  1  start request from loader; acted on at its rising edge
sample_in  in  32  four signed 8-bit inputs; byte k = input x[k]
unit_out  out  4  bit n = activation of unit n
done  out  1  one-cycle pulse, unit_out newly valid
busy  out  1  high from LOAD through DONE inclusive

Behaviour:
- Reset (async): state=IDLE; bank[0..3]=0; unit_out=0; done=0; busy=0; acc=0; unit/k counters=0; start_d=0.
- start_d registers start_network_controller every cycle in every state. Rise = start & ~start_d.
- Weight writes are accepted only in IDLE. writeData in any other state is dropped and the bank is unchanged. An IDLE write and a start rise in the same cycle: both take effect, and the new word is used.
- FSM:
  - IDLE: on rise -> LOAD; otherwise stay.
  - LOAD: capture sample_in into x_reg; acc=0, unit=0, k=0 -> MAC.
  - MAC: acc += sext18(w[unit][k]) * sext18(x_reg[k]); k++. After k==3 -> EVAL.
  - EVAL: res[unit] = (acc > THRESHOLD) signed; acc=0; k=0. If unit==3 -> DONE with unit_out<=res and done<=1. Else unit++ -> MAC.
  - DONE: done<=0 -> IDLE.
- Arithmetic: 8x8 signed product is 16-bit. Sum of 4 products fits the 18-bit signed acc (range -65024..+65536), so overflow is impossible. No saturation.
- Latency: call the edge that samples the start rise in IDLE E0. MACs execute at E2-E5, E7-E10, E12-E15, E17-E20. EVALs occur at E6, E11, E16, E21. unit_out updates and done rises at E21; done falls at E22. busy rises at E0 and falls at E22.
- unit_out holds its previous result throughout a run; it changes only at E21 (all 4 bits together).
- Start rise while busy is ignored and not queued. A start held high past completion does not retrigger; it must go low and then rise again.
- sample_in changes after LOAD do not affect the run.
- Reset mid-run aborts immediately. unit_out returns to 0 and the bank is cleared, so the loader must rewrite it.

Test Plan:
1. Assert reset, then release -> unit_out=0, done=0, busy=0. Starting with an empty bank and sample 0x01020304 gives all sums 0 -> unit_out=4'b0000, done at E21.
2. Write 0x01010101 to addr 0-3; sample 0x01020304; pulse start -> all sums 10 -> unit_out=4'b1111. done high exactly one cycle (E21-E22), busy high E0-E22.
3. Write w0=0x01010101, w1=0xFFFFFFFF, w2=0x7F7F7F7F, w3=0x80808080; sample 0x7F7F7F7F -> sums 508, -508, 64516, -65024 -> unit_out=4'b0101. Then sample 0x80808080 with w3 unchanged -> unit3 sum +65536, no wrap, so bit3=1.
4. Set THRESHOLD=10 with weights all 0x01010101. Sample 0x01020304 (sum 10) -> unit_out=4'b0000. Sample 0x01020305 (sum 11) -> unit_out=4'b1111.
5. During a run, write 0x00000000 to addr 0 and re-pulse start at E5; hold start high after E22 -> write dropped, only one done, result matches the pre-run bank, no retrigger until start goes low and rises again.
6. Assert reset at E12 of a run -> outputs and bank clear asynchronously within the same cycle, no done pulse. A fresh load and start then produces the correct result.

Source files
------------

// File: rtl/network_controller_if.sv
// network_controller_if
//   Bundles the weight-bank write port, the start/sample request and the
//   result outputs of the perceptron layer stage.
//   Handshake semantics: a weight word is taken on a rising clk edge when
//   writeData is high and the stage is idle; otherwise it is dropped. A run
//   begins on a 0->1 transition of start_network_controller seen while idle;
//   busy is high for the whole run and done pulses for exactly one cycle when
//   unit_out carries the new result. There is no back-pressure.
//   master : the loader side (drives weights, start, sample)
//   slave  : the compute stage (drives unit_out, done, busy, dbg_state)
interface network_controller_if;
   logic [31:0] weight_data;
   logic [1:0]  address;
   logic        writeData;
   logic        start_network_controller;
   logic [31:0] sample_in;
   logic [3:0]  unit_out;
   logic        done;
   logic        busy;
   logic [2:0]  dbg_state;

   modport master (
      output weight_data, address, writeData, start_network_controller, sample_in,
      input  unit_out, done, busy, dbg_state
   );

   modport slave (
      input  weight_data, address, writeData, start_network_controller, sample_in,
      output unit_out, done, busy, dbg_state
   );
endinterface

// File: rtl/network_controller.sv
// network_controller
//   4-input, 4-unit perceptron layer. Weight words are captured into a local
//   bank while idle; a start rise loads the sample and runs one signed 8x8 MAC
//   per cycle, then a step activation (sum > THRESHOLD) per unit.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high; clears all state
//     bus   : slave side of network_controller_if (weights, start, sample,
//             unit_out, done, busy, dbg_state = current FSM state)
module network_controller #(
   parameter logic signed [17:0] THRESHOLD = 18'sd0,
   parameter int                 NUM_UNITS = 4
) (
   input logic                 clk,
   input logic                 reset,
   network_controller_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MAC  = 3'd2,
      S_EVAL = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        bank_q [NUM_UNITS];
   logic [31:0]        bank_d [NUM_UNITS];
   logic [31:0]        x_q, x_d;
   logic signed [17:0] acc_q, acc_d;
   logic [1:0]         unit_q, unit_d;
   logic [1:0]         k_q, k_d;
   logic [3:0]         res_q, res_d;
   logic [3:0]         unit_out_q, unit_out_d;
   logic               done_q, done_d;
   logic               start_q;

   logic               rise;
   logic signed [7:0]  w_byte;
   logic signed [7:0]  x_byte;
   logic signed [15:0] prod;

   assign rise = bus.start_network_controller & ~start_q;

   // Byte k of the word/sample is operand k of the current unit.
   assign w_byte = bank_q[unit_q][{k_q, 3'b000} +: 8];
   assign x_byte = x_q[{k_q, 3'b000} +: 8];
   assign prod   = w_byte * x_byte;

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      x_d        = x_q;
      acc_d      = acc_q;
      unit_d     = unit_q;
      k_d        = k_q;
      res_d      = res_q;
      unit_out_d = unit_out_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A write in the same cycle as the start rise lands before the
            // first MAC, so the run sees the new word.
            if (bus.writeData) begin
               bank_d[bus.address] = bus.weight_data;
            end
            if (rise) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            x_d     = bus.sample_in;
            acc_d   = '0;
            unit_d  = '0;
            k_d     = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            // Sum of four 16-bit products always fits 18 bits signed.
            acc_d = acc_q + {{2{prod[15]}}, prod};
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            res_d[unit_q] = (acc_q > THRESHOLD);
            acc_d         = '0;
            k_d           = '0;
            if (unit_q == 2'd3) begin
               unit_out_d         = res_q;
               unit_out_d[unit_q] = (acc_q > THRESHOLD);
               done_d             = 1'b1;
               state_d            = S_DONE;
            end else begin
               unit_d  = unit_q + 2'd1;
               state_d = S_MAC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < NUM_UNITS; i++) begin
            bank_q[i] <= '0;
         end
         x_q        <= '0;
         acc_q      <= '0;
         unit_q     <= '0;
         k_q        <= '0;
         res_q      <= '0;
         unit_out_q <= '0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         unit_q     <= unit_d;
         k_q        <= k_d;
         res_q      <= res_d;
         unit_out_q <= unit_out_d;
         done_q     <= done_d;
         start_q    <= bus.start_network_controller;
      end
   end

   assign bus.unit_out  = unit_out_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_network_controller.sv
// tb_network_controller
//   Drives two instances (threshold 0 and threshold 10) with identical
//   stimulus; a reference model predicts each unit_out and monitors compare
//   whenever done is presented.
module tb_network_controller;

   logic clk = 1'b0;
   logic drv_rst;
   logic [31:0] drv_wd;
   logic [1:0]  drv_addr;
   logic        drv_we;
   logic        drv_start;
   logic [31:0] drv_sample;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [3:0]  exp_q0[$];
   logic [3:0]  exp_q1[$];
   logic [31:0] bank_m [4];

   network_controller_if b0 ();
   network_controller_if b1 ();

   assign b0.weight_data = drv_wd;
   assign b0.address     = drv_addr;
   assign b0.writeData   = drv_we;
   assign b0.start_network_controller = drv_start;
   assign b0.sample_in   = drv_sample;
   assign b1.weight_data = drv_wd;
   assign b1.address     = drv_addr;
   assign b1.writeData   = drv_we;
   assign b1.start_network_controller = drv_start;
   assign b1.sample_in   = drv_sample;

   network_controller #(.THRESHOLD(18'sd0)) dut0 (.clk(clk), .reset(drv_rst), .bus(b0));
   network_controller #(.THRESHOLD(18'sd10)) dut1 (.clk(clk), .reset(drv_rst), .bus(b1));

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: dot product of signed bytes, strict compare against threshold.
   function automatic logic [3:0] model(input logic [31:0] s, input int thr);
      logic [3:0] r;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         int sum;
         sum = 0;
         for (int k = 0; k < 4; k++) begin
            byte wb;
            byte xb;
            wb = bank_m[n][8*k +: 8];
            xb = s[8*k +: 8];
            sum += int'(wb) * int'(xb);
         end
         r[n] = (sum > thr);
      end
      return r;
   endfunction

   task automatic do_reset();
      drv_rst = 1'b1;
      drv_we = 1'b0; drv_start = 1'b0; drv_wd = '0; drv_addr = '0; drv_sample = '0;
      for (int i = 0; i < 4; i++) bank_m[i] = '0;
      repeat (2) @(negedge clk);
      drv_rst = 1'b0;
      @(negedge clk);
      check("rst_unit_out0", {28'd0, b0.unit_out}, 0);
      check("rst_done0", {31'd0, b0.done}, 0);
      check("rst_busy0", {31'd0, b0.busy}, 0);
      check("rst_unit_out1", {28'd0, b1.unit_out}, 0);
   endtask

   task automatic write_word(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      drv_wd = d; drv_addr = a; drv_we = 1'b1;
      bank_m[a] = d;
      @(negedge clk);
      drv_we = 1'b0;
   endtask

   // One run. same_wr: a bank write in the start cycle. disturb: write and
   // start re-pulse mid-run, start held after completion. abort: reset mid-run.
   task automatic run(input logic [31:0] s, input bit same_wr, input logic [1:0] wa,
                      input logic [31:0] wdat, input bit disturb, input bit abort);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      if (same_wr) begin
         drv_wd = wdat; drv_addr = wa; drv_we = 1'b1;
         bank_m[wa] = wdat;
      end
      drv_sample = s;
      drv_start = 1'b1;
      if (!abort) begin
         exp_q0.push_back(model(s, 0));
         exp_q1.push_back(model(s, 10));
      end
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         drv_we = 1'b0;
         if (i == 0) begin
            check("busy_rise0", {31'd0, b0.busy}, 1);
            check("busy_rise1", {31'd0, b1.busy}, 1);
            if (!disturb) drv_start = 1'b0;
         end
         if (i == 2) drv_sample = $urandom;
         if (i == 10) check("busy_mid", {31'd0, b0.busy}, 1);
         if (disturb && i == 3) begin
            drv_start = 1'b0; drv_wd = '0; drv_addr = 2'd0; drv_we = 1'b1;
         end
         if (disturb && i == 4) drv_start = 1'b1;
         if (abort && i == 11) begin
            #2 drv_rst = 1'b1;
            #1;
            check("abort_unit_out0", {28'd0, b0.unit_out}, 0);
            check("abort_done0", {31'd0, b0.done}, 0);
            check("abort_busy0", {31'd0, b0.busy}, 0);
            check("abort_busy1", {31'd0, b1.busy}, 0);
            for (int j = 0; j < 4; j++) bank_m[j] = '0;
            drv_start = 1'b0;
            @(negedge clk);
            drv_rst = 1'b0;
            return;
         end
         if (b0.done === 1'b1) begin
            seen = 1'b1;
            check("done_latency", i, 21);
            check("done_both", {31'd0, b1.done}, 1);
         end
      end
      if (!seen) begin
         total_cnt++;
         $display("FAIL done_timeout: no done within 40 cycles, expected at cycle 21");
      end
      @(negedge clk);
      check("done_fall", {31'd0, b0.done}, 0);
      check("busy_fall", {31'd0, b0.busy}, 0);
      if (disturb) begin
         repeat (5) begin
            @(negedge clk);
            check("no_retrigger", {31'd0, b0.busy}, 0);
         end
         drv_start = 1'b0;
      end
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (drv_rst === 1'b0 && b0.done === 1'b1) begin
         if (exp_q0.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done0: done seen with no run outstanding, unit_out=0x%0h", b0.unit_out);
         end else begin
            check("unit_out0", {28'd0, b0.unit_out}, {28'd0, exp_q0.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (drv_rst === 1'b0 && b1.done === 1'b1) begin
         if (exp_q1.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done1: done seen with no run outstanding, unit_out=0x%0h", b1.unit_out);
         end else begin
            check("unit_out1", {28'd0, b1.unit_out}, {28'd0, exp_q1.pop_front()});
         end
      end
   end

   initial begin
      do_reset();

      // empty bank: all sums zero
      run(32'h01020304, 0, 0, 0, 0, 0);

      // all-ones weights: sums 10 and 11 around both thresholds
      for (int a = 0; a < 4; a++) write_word(a[1:0], 32'h01010101);
      run(32'h01020304, 0, 0, 0, 0, 0);
      run(32'h01020305, 0, 0, 0, 0, 0);

      // extreme byte values
      write_word(2'd0, 32'h01010101);
      write_word(2'd1, 32'hFFFFFFFF);
      write_word(2'd2, 32'h7F7F7F7F);
      write_word(2'd3, 32'h80808080);
      run(32'h7F7F7F7F, 0, 0, 0, 0, 0);
      run(32'h80808080, 0, 0, 0, 0, 0);

      // mid-run write dropped, start re-pulse ignored, held start no retrigger
      run(32'h01020304, 0, 0, 0, 1, 0);
      run(32'h01020304, 0, 0, 0, 0, 0);

      // write in the same cycle as the start rise is used
      run(32'h05FB7F80, 1, 2'd1, 32'h11223344, 0, 0);

      // reset mid-run, then empty bank, then reload
      run(32'h01020304, 0, 0, 0, 0, 1);
      run(32'h01020304, 0, 0, 0, 0, 0);
      for (int a = 0; a < 4; a++) write_word(a[1:0], 32'h01010101);
      run(32'h01020305, 0, 0, 0, 0, 0);

      // randomized
      for (int r = 0; r < 10; r++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) write_word(2'($urandom_range(0, 3)), $urandom);
         run($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 0, 0);
      end

      repeat (3) @(negedge clk);
      check("exp_q0_drained", exp_q0.size(), 0);
      check("exp_q1_drained", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
